wb_reg_file: RTL and testbench

- Destination end of the write-back interface: the general-purpose register file that receives the WB stage's outputs (reg_write, regdst, data_to_reg).
- Serves the two ID-stage operand reads (rs, rt) and one debug read.
- Sits between WB (write port) and ID (read ports).
- Provides same-cycle write-to-read bypass, so an instruction in ID sees a value WB is committing in that same cycle. A separate WB→ID forwarding path is therefore not needed.

---
 rtl/wb_reg_file.sv | 115 +++++++++++
 tb/tb_wb_reg_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// ----------------------------------------------------------------------------
// wb_reg_file
// General-purpose register file at the destination end of the write-back
// interface. WB drives the single write port; ID reads two operands (rs, rt)
// and a debug port reads any entry.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset, clears every entry
//   reg_write    write enable from WB
//   regdst       destination register index from WB
//   data_to_reg  write data from WB
//   rs_addr      read port A index      -> rs_data  (bypassed when BYPASS=1)
//   rt_addr      read port B index      -> rt_data  (bypassed when BYPASS=1)
//   dbg_addr     debug read index       -> dbg_data (never bypassed)
//
// Entry 0 reads as zero on every port. Reads are combinational so that the
// ID stage sees operands in the same cycle it presents the addresses.
// ----------------------------------------------------------------------------
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] regdst,
    input  logic [DATA_W-1:0] data_to_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit BYPASS_EN = (BYPASS != 0);

    // Entry 0 is kept in the array only for simple indexing; it is never
    // written and every read of index 0 is forced to zero below.
    logic [DATA_W-1:0] regs_r [DEPTH];

    logic              wr_hit_s;
    logic [DATA_W-1:0] rs_stored_s;
    logic [DATA_W-1:0] rt_stored_s;

    // Qualified write: reset wins and index 0 is silently dropped. The same
    // qualifier gates the bypass so a discarded write is never forwarded.
    always_comb begin
        wr_hit_s = 1'b0;
        if (!rst && reg_write && (regdst != {ADDR_W{1'b0}})) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Storage update: synchronous clear, otherwise commit the qualified write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_hit_s) begin
            regs_r[regdst] <= data_to_reg;
        end
    end

    // Stored-value lookup for the operand ports, with index 0 forced to zero.
    always_comb begin
        rs_stored_s = {DATA_W{1'b0}};
        rt_stored_s = {DATA_W{1'b0}};
        if (rs_addr != {ADDR_W{1'b0}}) begin
            rs_stored_s = regs_r[rs_addr];
        end else begin
            rs_stored_s = {DATA_W{1'b0}};
        end
        if (rt_addr != {ADDR_W{1'b0}}) begin
            rt_stored_s = regs_r[rt_addr];
        end else begin
            rt_stored_s = {DATA_W{1'b0}};
        end
    end

    // Operand ports: forward the in-flight WB value on an address match.
    // wr_hit_s already excludes regdst==0, so a match implies a nonzero
    // read index and register zero can never be bypassed.
    always_comb begin
        rs_data = rs_stored_s;
        rt_data = rt_stored_s;
        if (BYPASS_EN && wr_hit_s && (regdst == rs_addr)) begin
            rs_data = data_to_reg;
        end else begin
            rs_data = rs_stored_s;
        end
        if (BYPASS_EN && wr_hit_s && (regdst == rt_addr)) begin
            rt_data = data_to_reg;
        end else begin
            rt_data = rt_stored_s;
        end
    end

    // Debug port: committed state only, index 0 forced to zero.
    always_comb begin
        dbg_data = {DATA_W{1'b0}};
        if (dbg_addr != {ADDR_W{1'b0}}) begin
            dbg_data = regs_r[dbg_addr];
        end else begin
            dbg_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_wb_reg_file
// Directed bench for wb_reg_file. Two instances share all inputs: dut has
// same-cycle bypass enabled, dut_nb has it disabled. Inputs change 1 ns after
// the rising edge; outputs are sampled a further 1 ns later, well before the
// next edge.
// ----------------------------------------------------------------------------
module tb_wb_reg_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  regdst;
    logic [31:0] data_to_reg;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] rs_data, rt_data, dbg_data;
    logic [31:0] rs_data_nb, rt_data_nb, dbg_data_nb;

    int pass_cnt;
    int total_cnt;

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .regdst(regdst),
        .data_to_reg(data_to_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .reg_write(reg_write), .regdst(regdst),
        .data_to_reg(data_to_reg), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_nb), .rt_data(rt_data_nb), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        reg_write   = 1'b0;
        regdst      = 5'd0;
        data_to_reg = 32'h0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
        dbg_addr    = 5'd0;
        tick();
        tick();

        // Reset state
        rst = 1'b0; rs_addr = 5'd5; rt_addr = 5'd31; dbg_addr = 5'd17;
        #1;
        check("reset_rs", rs_data, 32'h0);
        check("reset_rt", rt_data, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);

        // Reset clear: commit r5, then reset with a concurrent write to r6
        reg_write = 1'b1; regdst = 5'd5; data_to_reg = 32'hDEADBEEF; dbg_addr = 5'd5;
        #1;
        check("r5_dbg_precommit", dbg_data, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r5_dbg_commit", dbg_data, 32'hDEADBEEF);
        rst = 1'b1; reg_write = 1'b1; regdst = 5'd6; data_to_reg = 32'h1; rs_addr = 5'd6;
        #1;
        check("rst_gates_bypass", rs_data, 32'h0);
        tick();
        rst = 1'b0; reg_write = 1'b0;
        #1;
        check("r5_cleared", dbg_data, 32'h0);
        dbg_addr = 5'd6;
        #1;
        check("r6_write_in_rst_dropped", dbg_data, 32'h0);

        // Write/commit to r8
        reg_write = 1'b1; regdst = 5'd8; data_to_reg = 32'h12345678; dbg_addr = 5'd8; rs_addr = 5'd8;
        #1;
        check("r8_dbg_same_cycle", dbg_data, 32'h0);
        check("r8_rs_bypass", rs_data, 32'h12345678);
        check("r8_rs_nobypass", rs_data_nb, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r8_dbg_next", dbg_data, 32'h12345678);

        // Bypass on both ports
        reg_write = 1'b1; regdst = 5'd9; data_to_reg = 32'h11;
        tick();
        data_to_reg = 32'h22; rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        check("r9_rs_bypass", rs_data, 32'h22);
        check("r9_rt_bypass", rt_data, 32'h22);
        check("r9_rs_nb_old", rs_data_nb, 32'h11);
        check("r9_rt_nb_old", rt_data_nb, 32'h11);
        tick();
        reg_write = 1'b0;
        #1;
        check("r9_rs_nb_next", rs_data_nb, 32'h22);
        check("r9_rt_next", rt_data, 32'h22);

        // Register zero
        reg_write = 1'b1; regdst = 5'd0; data_to_reg = 32'hFFFFFFFF; rs_addr = 5'd0; dbg_addr = 5'd0;
        #1;
        check("r0_rs_same", rs_data, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_rs_after", rs_data, 32'h0);
        check("r0_dbg_after", dbg_data, 32'h0);

        // Write disabled
        regdst = 5'd3; data_to_reg = 32'hABCD; rt_addr = 5'd3;
        #1;
        check("wdis_rt_same", rt_data, 32'h0);
        tick();
        check("wdis_rt_next", rt_data, 32'h0);

        // Consecutive overwrite of r31 then reset with a write
        reg_write = 1'b1; regdst = 5'd31; rs_addr = 5'd31; dbg_addr = 5'd31; data_to_reg = 32'hA;
        #1;
        check("r31_a", rs_data, 32'hA);
        tick();
        data_to_reg = 32'hB;
        #1;
        check("r31_b", rs_data, 32'hB);
        check("r31_dbg_a", dbg_data, 32'hA);
        tick();
        data_to_reg = 32'hC;
        #1;
        check("r31_c", rs_data, 32'hC);
        tick();
        rst = 1'b1; data_to_reg = 32'h5;
        #1;
        check("r31_rs_stored_c", rs_data, 32'hC);
        check("r31_dbg_stored_c", dbg_data, 32'hC);
        tick();
        rst = 1'b0; reg_write = 1'b0;
        #1;
        check("r31_after_rst_dbg", dbg_data, 32'h0);
        check("r31_after_rst_rs", rs_data, 32'h0);

        // First edge with rst=0 accepts a write
        reg_write = 1'b1; data_to_reg = 32'h7;
        tick();
        reg_write = 1'b0;
        #1;
        check("r31_post_rst_write", dbg_data, 32'h7);
        check("r31_post_rst_nb", rs_data_nb, 32'h7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
